// File: rtl/alu_op_sequencer.sv
// Queues packed ALU commands, drives each onto the ALU bus, waits a fixed settle
// time, then captures and holds the ALU result until the consumer takes it.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic [7:0] alu_op,
    input  logic [7:0] alu_res,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] rsp_op,
    output logic [7:0] ovf_count,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SET_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   occ;
    logic [CNT_W-1:0]   occ_nxt;
    logic [SET_W-1:0]   settle_cnt;
    logic [SET_W-1:0]   settle_nxt;
    logic [DATA_W-1:0]  alu_op_nxt;
    logic [DATA_W-1:0]  rsp_data_nxt;
    logic [DATA_W-1:0]  rsp_op_nxt;
    logic [DATA_W-1:0]  ovf_nxt;
    logic               rsp_valid_nxt;
    logic               push;
    logic               pop;
    logic               fifo_empty;

    // cmd_ready is the registered "not full" flag, so a full FIFO never takes a push
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (occ == '0);

    // Command payload storage; occupancy qualifies the contents, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_data;
        end
    end

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + CNT_W'(1);
            2'b01:   occ_nxt = occ - CNT_W'(1);
            default: occ_nxt = occ;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        settle_nxt    = settle_cnt;
        alu_op_nxt    = alu_op;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_op_nxt    = rsp_op;
        ovf_nxt       = ovf_count;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    alu_op_nxt = fifo_mem[rd_ptr];
                    rsp_op_nxt = fifo_mem[rd_ptr];
                    settle_nxt = SET_W'(SETTLE_CYCLES);
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SET_W'(1)) begin
                    rsp_data_nxt  = alu_res;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = HOLD;
                    if (alu_res[7] && (ovf_count != 8'hFF)) begin
                        ovf_nxt = ovf_count + 8'd1;
                    end
                end else begin
                    settle_nxt = settle_cnt - SET_W'(1);
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            settle_cnt <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_op     <= '0;
            ovf_count  <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ        <= occ_nxt;
            settle_cnt <= settle_nxt;
            alu_op     <= alu_op_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_data   <= rsp_data_nxt;
            rsp_op     <= rsp_op_nxt;
            ovf_count  <= ovf_nxt;
            cmd_ready  <= (occ_nxt != CNT_W'(FIFO_DEPTH));
            busy       <= (state_nxt != IDLE) || (occ_nxt != '0);
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer against a transaction-level
// scoreboard and a behavioural ALU model; a second instance uses SETTLE_CYCLES=3.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [7:0] cmd_data, alu_op, alu_res, rsp_data, rsp_op, ovf_count;
    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, busy3;
    logic [7:0] cmd_data3, alu_op3, alu_res3, rsp_data3, rsp_op3, ovf_count3;
    logic       force_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_rsp    = 0;
    int unsigned ovf_model = 0;
    bit  tp_en   = 1'b0;
    int  tp_prev = -1;
    logic [7:0] exp_op_q[$];
    logic [7:0] exp_data_q[$];
    logic [7:0] op_e, data_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: {OVF, NEG, ZERO, CARRY, RESULT} from the packed op byte
    function automatic logic [7:0] alu_f(input logic [7:0] op);
        logic [4:0] a, b, r;
        logic       c, v;
        logic [3:0] res;
        a = {3'b000, op[1:0]};
        b = {3'b000, op[3:2]};
        v = 1'b0;
        case (op[6:4])
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << op[7];
            3'd6:    r = a * b;
            default: begin r = a + b; v = 1'b1; end
        endcase
        res = r[3:0];
        c   = (op[6:4] == 3'd1) ? ~r[4] : r[4];
        return {v, res[3], (res == 4'h0), c, res};
    endfunction

    assign alu_res  = force_ovf ? 8'h80 : alu_f(alu_op);
    assign alu_res3 = alu_f(alu_op3);

    alu_op_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .alu_op(alu_op), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .ovf_count(ovf_count), .busy(busy)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_data(cmd_data3), .alu_op(alu_op3), .alu_res(alu_res3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .rsp_op(rsp_op3), .ovf_count(ovf_count3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes are decided at the next rising edge, so sample mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_op_q.delete();
            exp_data_q.delete();
            ovf_model = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                exp_op_q.push_back(cmd_data);
                exp_data_q.push_back(force_ovf ? 8'h80 : alu_f(cmd_data));
                n_acc++;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_op_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    op_e   = exp_op_q.pop_front();
                    data_e = exp_data_q.pop_front();
                    check("rsp_op", 32'(rsp_op), 32'(op_e));
                    check("rsp_data", 32'(rsp_data), 32'(data_e));
                    if (data_e[7] && ovf_model < 255) ovf_model++;
                end
                n_rsp++;
                if (tp_en) begin
                    if (tp_prev >= 0) check("throughput", 32'(cyc - tp_prev), 32'd3);
                    tp_prev = cyc;
                end
            end
        end
    end

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((busy || rsp_valid || exp_op_q.size() != 0) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(n < max_cyc), 32'd1);
    endtask

    // Directed single command on the default instance: push, then expect capture at +2
    task automatic single_cmd(input logic [7:0] op, input logic [7:0] exp_data, input logic rdy);
        rsp_ready = rdy;
        cmd_valid = 1'b1;
        cmd_data  = op;
        step();
        cmd_valid = 1'b0;
        check("busy_after_push", 32'(busy), 32'd1);
        step();
        check("rsp_valid_at_plus1", 32'(rsp_valid), 32'd0);
        check("alu_op_issued", 32'(alu_op), 32'(op));
        step();
        check("rsp_valid_at_plus2", 32'(rsp_valid), 32'd1);
        check("rsp_data_direct", 32'(rsp_data), 32'(exp_data));
        check("rsp_op_direct", 32'(rsp_op), 32'(op));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_released", 32'(rsp_valid), 32'd0);
    endtask

    task automatic settle3_cmd(input logic [7:0] op);
        int n;
        check("ready3_before", 32'(cmd_ready3), 32'd1);
        cmd_valid3 = 1'b1;
        cmd_data3  = op;
        step();
        cmd_valid3 = 1'b0;
        n = 0;
        while (!rsp_valid3 && n < 10) begin
            step();
            n++;
        end
        check("latency3", 32'(n), 32'd4);
        check("rsp_data3", 32'(rsp_data3), 32'(alu_f(op)));
        check("rsp_op3", 32'(rsp_op3), 32'(op));
        check("alu_op3", 32'(alu_op3), 32'(op));
        rsp_ready3 = 1'b1;
        step();
        rsp_ready3 = 1'b0;
        check("rsp_valid3_released", 32'(rsp_valid3), 32'd0);
        check("busy3_idle", 32'(busy3), 32'd0);
    endtask

    initial begin
        int guard;
        int start_acc;
        int rsp_before;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
        cmd_valid3 = 1'b0; cmd_data3 = '0; rsp_ready3 = 1'b0;
        force_ovf = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu_op", 32'(alu_op), 32'h00);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'h00);
        check("rst_rsp_op", 32'(rsp_op), 32'h00);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Add then subtract; the subtract keeps rsp_ready high through SETTLE
        single_cmd(8'h09, 8'h03, 1'b0);
        single_cmd(8'h19, 8'h4F, 1'b1);

        // Five pushes into a stalled consumer: one issued, four queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = 8'($urandom);
            check("ready_before_push", 32'(cmd_ready), 32'd1);
            step();
        end
        cmd_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            check("full_cmd_ready", 32'(cmd_ready), 32'd0);
            step();
        end
        cmd_valid = 1'b0;
        check("full_busy", 32'(busy), 32'd1);
        check("full_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("full_after_release", 32'(cmd_ready), 32'd0);
        step();
        check("ready_after_pop", 32'(cmd_ready), 32'd1);
        tp_en = 1'b1;
        tp_prev = -1;
        rsp_ready = 1'b1;
        wait_idle(200);
        tp_en = 1'b0;
        check("full_order_drained", 32'(exp_op_q.size()), 32'd0);

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_data  = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle(300);
        check("ovf_count_random", 32'(ovf_count), 32'(ovf_model));

        // Saturation: every capture reports overflow
        force_ovf = 1'b1;
        rsp_ready = 1'b1;
        start_acc = n_acc;
        guard = 0;
        cmd_valid = 1'b1;
        while ((n_acc - start_acc) < 260 && guard < 3000) begin
            cmd_data = 8'($urandom);
            step();
            guard++;
        end
        cmd_valid = 1'b0;
        check("sat_push_count", 32'(n_acc - start_acc), 32'd260);
        wait_idle(300);
        check("ovf_count_sat", 32'(ovf_count), 32'd255);
        check("ovf_count_model", 32'(ovf_count), 32'(ovf_model));
        force_ovf = 1'b0;

        // Reset in HOLD with three commands still queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = 8'($urandom_range(1, 255));
            step();
        end
        cmd_valid = 1'b0;
        check("hold_before_rst", 32'(rsp_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'h00);
        check("midrst_ovf_count", 32'(ovf_count), 32'd0);
        step();
        rst = 1'b0;
        rsp_before = n_rsp;
        rsp_ready = 1'b1;
        repeat (20) step();
        check("postrst_no_rsp", 32'(n_rsp - rsp_before), 32'd0);
        check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("postrst_alu_op", 32'(alu_op), 32'h00);
        check("postrst_busy", 32'(busy), 32'd0);
        single_cmd(8'h09, 8'h03, 1'b0);

        // SETTLE_CYCLES=3 instance
        settle3_cmd(8'h09);
        settle3_cmd(8'h19);
        for (int i = 0; i < 4; i++) settle3_cmd(8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: clock edges the ALU output is allowed to settle after an op is driven (legal range 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4: command FIFO entries (power of two, 2..16).
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  FIFO can accept a command.
REQ-008 cmd_data  input  8  packed command {s_amt[7], control[6:4], B[3:2], A[1:0]}.
REQ-009 alu_op  output  8  operand/control byte driven to the ALU input bus, same packing as cmd_data.
REQ-010 alu_res  input  8  ALU output byte {OVERFLOW[7], NEGATIVE[6], ZERO[5], CARRY[4], RESULT[3:0]}.
REQ-011 rsp_valid  output  1  response held.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_data  output  8  captured alu_res.
REQ-014 rsp_op  output  8  command that produced rsp_data.
REQ-015 ovf_count  output  8  saturating count of captured responses with OVERFLOW set.
REQ-016 busy  output  1  high when FSM is not IDLE or FIFO is non-empty.

Function
REQ-017 cmd_ready shall equal "FIFO not full"; a push occurs on any edge with cmd_valid && cmd_ready.
REQ-018 A push into a full FIFO shall not occur, even when a pop happens on the same edge (no pass-through).
REQ-019 Simultaneous push and pop on a non-full, non-empty FIFO shall leave the occupancy unchanged and preserve FIFO order.
REQ-020 FSM states: IDLE, SETTLE and HOLD only.
REQ-021 IDLE with FIFO non-empty: on the next edge, pop the head into alu_op and rsp_op, load the settle counter with SETTLE_CYCLES, and move to SETTLE.
REQ-022 IDLE with FIFO empty: remain in IDLE with alu_op unchanged.
REQ-023 SETTLE: on each edge, if the counter equals 1, capture alu_res into rsp_data, set rsp_valid, and move to HOLD; otherwise decrement the counter.
REQ-024 HOLD: rsp_valid, rsp_data and rsp_op shall stay stable until an edge with rsp_ready high; on that edge, clear rsp_valid and return to IDLE.
REQ-025 rsp_ready while rsp_valid is low shall have no effect.
REQ-026 alu_op shall change only on a pop; it holds the last issued op between commands.
REQ-027 Latency: a command pushed into an empty FIFO while the FSM is in IDLE shall have rsp_valid high after SETTLE_CYCLES+2 edges, counted from and including the push edge. With the default, rsp_valid is high after push edge + 2.
REQ-028 Back-to-back throughput: one response per SETTLE_CYCLES+2 cycles when rsp_ready is held high.
REQ-029 ovf_count shall increment on each capture with alu_res[7]=1 and saturate at 255, with no wrap.
REQ-030 The FIFO pointers shall wrap modulo FIFO_DEPTH; occupancy 0..FIFO_DEPTH shall be tracked exactly.

Reset
REQ-031 While rst is high, all outputs and state shall take their reset values asynchronously:
- FSM: IDLE
- FIFO: emptied
- cmd_ready: 1
- alu_op: 0x00
- rsp_valid: 0
- rsp_data: 0x00
- rsp_op: 0x00
- ovf_count: 0
- busy: 0
REQ-032 A reset asserted mid-operation (SETTLE or HOLD) shall discard the in-flight command and all queued commands; no response is emitted for them.
REQ-033 After rst deasserts, the first push shall be accepted on the first rising edge with cmd_valid high.

Verification
REQ-034 The bench shall model the ALU combinationally (alu_res = f(alu_op)) and cover the following scenarios:
- Add: push 0x09 (A=1, B=2, ADD) into idle -> rsp_valid after 2 edges (default), alu_op=0x09, rsp_data=0x03, rsp_op=0x09.
- Subtract: push 0x19 (1-2, SUB) -> rsp_data=0x4F (RESULT=F, NEG=1, CARRY=0, OVF=0).
- Full FIFO with stalled consumer: push 5 commands back-to-back with rsp_ready=0 -> 1 issued plus 4 queued, cmd_ready=0 until rsp_ready pulses; response order matches push order.
- Overflow saturation: bench forces alu_res=0x80 for 260 commands -> ovf_count saturates at 255.
- Reset mid-operation: rst pulsed in HOLD with 3 commands queued -> rsp_valid=0, cmd_ready=1, busy=0, alu_op=0x00, no further responses.
- SETTLE_CYCLES=3 build: latency is push edge + 4; rsp_data matches the ALU value sampled on the capture edge.
